// File: rtl/nvlink_pkg.sv
// Shared definitions for the NVLink flit receiver: field offsets, the FSM
// state encoding and the CRC-16-CCITT used to qualify incoming flits.
package nvlink_pkg;

  localparam int SEQ_MSB    = 127;
  localparam int SEQ_LSB    = 120;
  localparam int COH_MSB    = 119;
  localparam int COH_LSB    = 112;
  localparam int PAY_MSB    = 111;
  localparam int PAY_LSB    = 16;
  localparam int CRC_MSB    = 15;
  localparam int CRC_LSB    = 0;
  localparam int CRC_DATA_W = SEQ_MSB - CRC_MSB;
  localparam int PAY_W      = PAY_MSB - PAY_LSB + 1;
  localparam int ENTRY_W    = SEQ_MSB - PAY_LSB + 1;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_NAK_WAIT = 2'd2
  } rx_state_e;

  // MSB-first serial form, no reflection and no final XOR.
  function automatic logic [15:0] crc16_ccitt(input logic [CRC_DATA_W-1:0] data);
    logic [15:0] crc;
    logic        fb;
    crc = CRC_INIT;
    for (int i = CRC_DATA_W - 1; i >= 0; i--) begin
      fb  = crc[15] ^ data[i];
      crc = {crc[14:0], 1'b0};
      if (fb) crc = crc ^ CRC_POLY;
    end
    return crc;
  endfunction

endpackage

// File: rtl/nvlink_rx_fifo.sv
// Count-based synchronous FIFO holding accepted flits; head is shown
// combinationally so a push into an empty FIFO is visible the next cycle.
module nvlink_rx_fifo #(
  parameter int DATA_W = 112,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_flush,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              w_do_push;
  logic              w_do_pop;

  // Full is judged before this cycle's pop, so a push to a full FIFO is
  // refused even when the consumer drains an entry in the same cycle.
  assign o_full    = (r_count == CW'(DEPTH));
  assign o_valid   = (r_count != '0);
  assign w_do_push = i_push & ~o_full & ~i_flush;
  assign w_do_pop  = i_pop & o_valid & ~i_flush;
  assign o_data    = o_valid ? r_mem[r_rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/nvlink_flit_receiver.sv
// NVLink flit receiver: CRC and sequence checking, in-order acceptance into
// a buffer, ACK/NAK generation with NAK re-issue, and error statistics.
module nvlink_flit_receiver
  import nvlink_pkg::*;
#(
  parameter int FLIT_W      = 128,
  parameter int FIFO_DEPTH  = 8,
  parameter int NAK_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [FLIT_W-1:0] flit_in,
  input  logic              flit_valid,
  input  logic              link_up,
  input  logic              cdr_lock,
  output logic [95:0]       out_payload,
  output logic [7:0]        out_coh,
  output logic [7:0]        out_seq,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              ack_valid,
  output logic [7:0]        ack_seq,
  output logic              nak_valid,
  output logic [7:0]        nak_seq,
  output logic [15:0]       crc_err_cnt,
  output logic [15:0]       seq_err_cnt,
  output logic [1:0]        state
);

  localparam int TMR_W = $clog2(NAK_TIMEOUT + 1);

  function automatic logic [15:0] sat_inc16(input logic [15:0] cnt);
    return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
  endfunction

  rx_state_e          r_state;
  rx_state_e          w_state_nxt;
  logic [7:0]         r_exp_seq;
  logic [TMR_W-1:0]   r_nak_tmr;
  logic               r_ack_vld_p1;
  logic [7:0]         r_ack_seq_p1;
  logic               r_nak_vld_p1;
  logic [7:0]         r_nak_seq_p1;
  logic [15:0]        r_crc_err_cnt;
  logic [15:0]        r_seq_err_cnt;

  logic [7:0]         w_seq;
  logic [7:0]         w_coh;
  logic [PAY_W-1:0]   w_pay;
  logic [15:0]        w_crc_calc;
  logic               w_crc_ok;
  logic               w_seq_exp;
  logic               w_seq_dup;
  logic               w_link_ok;
  logic               w_full;
  logic [ENTRY_W-1:0] w_head;

  logic               w_flush;
  logic               w_push;
  logic               w_ack;
  logic               w_nak;
  logic               w_crc_inc;
  logic               w_seq_inc;

  assign w_seq      = flit_in[SEQ_MSB:SEQ_LSB];
  assign w_coh      = flit_in[COH_MSB:COH_LSB];
  assign w_pay      = flit_in[PAY_MSB:PAY_LSB];
  assign w_crc_calc = crc16_ccitt(flit_in[SEQ_MSB:CRC_MSB+1]);
  assign w_crc_ok   = (w_crc_calc == flit_in[CRC_MSB:CRC_LSB]);
  assign w_seq_exp  = (w_seq == r_exp_seq);
  assign w_seq_dup  = (w_seq == (r_exp_seq - 8'd1));
  assign w_link_ok  = link_up & cdr_lock;

  always_comb begin
    w_state_nxt = r_state;
    w_flush     = 1'b0;
    w_push      = 1'b0;
    w_ack       = 1'b0;
    w_nak       = 1'b0;
    w_crc_inc   = 1'b0;
    w_seq_inc   = 1'b0;
    if (!w_link_ok) begin
      w_state_nxt = ST_IDLE;
      w_flush     = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: w_state_nxt = ST_RUN;
        ST_RUN: begin
          if (flit_valid) begin
            if (!w_crc_ok) begin
              w_crc_inc   = 1'b1;
              w_nak       = 1'b1;
              w_state_nxt = ST_NAK_WAIT;
            end else if (w_seq_exp) begin
              if (w_full) begin
                w_nak       = 1'b1;
                w_state_nxt = ST_NAK_WAIT;
              end else begin
                w_push = 1'b1;
                w_ack  = 1'b1;
              end
            end else if (w_seq_dup) begin
              w_ack = 1'b1;
            end else begin
              w_seq_inc   = 1'b1;
              w_nak       = 1'b1;
              w_state_nxt = ST_NAK_WAIT;
            end
          end
        end
        ST_NAK_WAIT: begin
          // Only the replayed expected flit gets through; everything else is
          // dropped silently while the timer decides when to ask again.
          if (flit_valid && w_crc_ok && w_seq_exp && !w_full) begin
            w_push      = 1'b1;
            w_ack       = 1'b1;
            w_state_nxt = ST_RUN;
          end else if (r_nak_tmr == TMR_W'(NAK_TIMEOUT - 1)) begin
            w_nak = 1'b1;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Stage p0 -> p1: decision registered into control state and pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_exp_seq     <= 8'd0;
      r_nak_tmr     <= '0;
      r_ack_vld_p1  <= 1'b0;
      r_ack_seq_p1  <= 8'd0;
      r_nak_vld_p1  <= 1'b0;
      r_nak_seq_p1  <= 8'd0;
      r_crc_err_cnt <= 16'd0;
      r_seq_err_cnt <= 16'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_ack_vld_p1 <= w_ack;
      r_nak_vld_p1 <= w_nak;
      if (w_ack) r_ack_seq_p1 <= w_seq;
      if (w_nak) r_nak_seq_p1 <= r_exp_seq;
      if (w_flush)     r_exp_seq <= 8'd0;
      else if (w_push) r_exp_seq <= r_exp_seq + 8'd1;
      if (w_nak)
        r_nak_tmr <= '0;
      else if (r_state == ST_NAK_WAIT && w_state_nxt == ST_NAK_WAIT)
        r_nak_tmr <= r_nak_tmr + TMR_W'(1);
      else
        r_nak_tmr <= '0;
      if (w_crc_inc) r_crc_err_cnt <= sat_inc16(r_crc_err_cnt);
      if (w_seq_inc) r_seq_err_cnt <= sat_inc16(r_seq_err_cnt);
    end
  end

  nvlink_rx_fifo #(
    .DATA_W (ENTRY_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (w_flush),
    .i_push  (w_push),
    .i_data  ({w_seq, w_coh, w_pay}),
    .i_pop   (out_ready),
    .o_data  (w_head),
    .o_valid (out_valid),
    .o_full  (w_full)
  );

  assign out_seq     = w_head[ENTRY_W-1 -: 8];
  assign out_coh     = w_head[ENTRY_W-9 -: 8];
  assign out_payload = w_head[PAY_W-1:0];
  assign ack_valid   = r_ack_vld_p1;
  assign ack_seq     = r_ack_seq_p1;
  assign nak_valid   = r_nak_vld_p1;
  assign nak_seq     = r_nak_seq_p1;
  assign crc_err_cnt = r_crc_err_cnt;
  assign seq_err_cnt = r_seq_err_cnt;
  assign state       = r_state;

endmodule
